// File: rtl/exec_step_controller.sv
// Run/stop/single-step sequencer for the core: debounced EXEC/STEP buttons, PC breakpoint,
// core halt, stretched core reset and a single datapath clock enable (no gated clock).

module exec_step_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DB_W            = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_press
);

  logic            r_s1;
  logic            r_s2;
  logic            r_level;
  logic [DB_W-1:0] r_cnt;
  logic            w_flip;

  // The flip is decided combinationally so the press pulse coincides with the level change.
  assign w_flip  = (r_s2 != r_level) && (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
  assign o_press = w_flip & r_s2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_cnt   <= '0;
        r_level <= r_s2;
      end else begin
        r_cnt <= r_cnt + DB_W'(1);
      end
    end
  end

endmodule

// state   | meaning
// STOP    | idle, waits for EXEC (run) or STEP (one instruction)
// RUN     | CPU_EN every cycle until EXEC, breakpoint or halt
// STEP    | exactly one CPU_EN cycle, then back to STOP (or HALTED)
// HALTED  | core executed halt; only RESET leaves
module exec_step_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DB_W            = 16,
  parameter int PC_W            = 8,
  parameter int RST_HOLD        = 4,
  parameter int CNT_W           = 16
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             EXEC,
  input  logic             STEP,
  input  logic             HALT_REQ,
  input  logic             BP_EN,
  input  logic [PC_W-1:0]  BP_ADDR,
  input  logic [PC_W-1:0]  PC,
  output logic             CPU_EN,
  output logic             RES_SIG,
  output logic             RUNNING,
  output logic [1:0]       STATE,
  output logic [CNT_W-1:0] INSTR_CNT
);

  typedef enum logic [1:0] {
    ST_STOP   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_bp_armed;
  logic               w_bp_armed_nxt;
  logic               r_res;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [CNT_W-1:0]   r_instr_cnt;
  logic               w_exec_p;
  logic               w_step_p;
  logic               w_bp_hit;
  logic               w_cpu_en;

  exec_step_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_W            (DB_W)
  ) u_db_exec (
    .i_clk   (CLOCK),
    .i_rst   (RESET),
    .i_raw   (EXEC),
    .o_press (w_exec_p)
  );

  exec_step_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_W            (DB_W)
  ) u_db_step (
    .i_clk   (CLOCK),
    .i_rst   (RESET),
    .i_raw   (STEP),
    .o_press (w_step_p)
  );

  // Reset stretch: down-counter, RES_SIG drops on the edge that reaches terminal count.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_hold_cnt <= HOLD_W'(RST_HOLD);
      r_res      <= 1'b1;
    end else if (r_hold_cnt != '0) begin
      r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
      if (r_hold_cnt == HOLD_W'(1)) begin
        r_res <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state    <= ST_STOP;
      r_bp_armed <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bp_armed <= w_bp_armed_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_bp_armed_nxt = r_bp_armed;
    w_cpu_en       = 1'b0;
    w_bp_hit       = BP_EN && (PC == BP_ADDR) && r_bp_armed;
    case (r_state)
      ST_STOP: begin
        if (!r_res) begin
          if (w_exec_p) begin
            w_state_nxt    = ST_RUN;
            w_bp_armed_nxt = 1'b0;
          end else if (w_step_p) begin
            w_state_nxt = ST_STEP;
          end
        end
      end
      ST_RUN: begin
        w_cpu_en = !w_bp_hit;
        // Arming after the first executed instruction lets a resume at BP_ADDR proceed.
        if (w_cpu_en) begin
          w_bp_armed_nxt = 1'b1;
        end
        if (HALT_REQ && w_cpu_en) begin
          w_state_nxt = ST_HALTED;
        end else if (w_exec_p) begin
          w_state_nxt = ST_STOP;
        end else if (w_bp_hit) begin
          w_state_nxt = ST_STOP;
        end
      end
      ST_STEP: begin
        w_cpu_en    = 1'b1;
        w_state_nxt = HALT_REQ ? ST_HALTED : ST_STOP;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_instr_cnt <= '0;
    end else if (w_cpu_en) begin
      r_instr_cnt <= r_instr_cnt + CNT_W'(1);
    end
  end

  assign CPU_EN    = w_cpu_en;
  assign RES_SIG   = r_res;
  assign RUNNING   = (r_state == ST_RUN);
  assign STATE     = r_state;
  assign INSTR_CNT = r_instr_cnt;

endmodule

// File: tb/tb_exec_step_controller.sv
// Bench for exec_step_controller: directed scenarios then random buttons, checked every cycle
// against a behavioural model; a second instance uses a longer reset hold and a 4-bit counter.
module tb_exec_step_controller;

  localparam int D     = 4;
  localparam int HOLD0 = 4;
  localparam int HOLD1 = 8;
  localparam int S_STOP = 0, S_RUN = 1, S_STEP = 2, S_HALT = 3;

  logic       CLOCK = 1'b0;
  logic       RESET, EXEC, STEP, HALT_REQ, BP_EN;
  logic [7:0] BP_ADDR, PC;
  logic       cpu_en0, res0, run0, cpu_en1, res1, run1;
  logic [1:0] st0, st1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLOCK = ~CLOCK;

  exec_step_controller #(.DEBOUNCE_CYCLES(D), .DB_W(16), .PC_W(8), .RST_HOLD(HOLD0), .CNT_W(16)) dut0 (
    .CLOCK(CLOCK), .RESET(RESET), .EXEC(EXEC), .STEP(STEP), .HALT_REQ(HALT_REQ), .BP_EN(BP_EN),
    .BP_ADDR(BP_ADDR), .PC(PC), .CPU_EN(cpu_en0), .RES_SIG(res0), .RUNNING(run0), .STATE(st0),
    .INSTR_CNT(cnt0));

  exec_step_controller #(.DEBOUNCE_CYCLES(D), .DB_W(16), .PC_W(8), .RST_HOLD(HOLD1), .CNT_W(4)) dut1 (
    .CLOCK(CLOCK), .RESET(RESET), .EXEC(EXEC), .STEP(STEP), .HALT_REQ(HALT_REQ), .BP_EN(BP_EN),
    .BP_ADDR(BP_ADDR), .PC(PC), .CPU_EN(cpu_en1), .RES_SIG(res1), .RUNNING(run1), .STATE(st1),
    .INSTR_CNT(cnt1));

  // Model: raw button samples per edge; a level is accepted once the synchronised copy
  // (raw sample two edges back) has differed from the accepted level for D samples in a row.
  typedef bit bq_t[$];
  bq_t qe, qs;
  bit  db_e, db_s;
  int          m_state[2];
  int unsigned m_cnt[2];
  bit          m_armed[2];
  int          m_hold[2];

  function automatic bit settled_other(input bq_t q, input bit db);
    for (int i = 0; i < D; i++) begin
      if (q[q.size() - 3 - i] == db) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_reset();
    qe.delete();
    qs.delete();
    for (int i = 0; i < D + 2; i++) begin
      qe.push_back(1'b0);
      qs.push_back(1'b0);
    end
    db_e = 1'b0;
    db_s = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_state[k] = S_STOP;
      m_cnt[k]   = 0;
      m_armed[k] = 1'b0;
    end
    m_hold[0] = HOLD0;
    m_hold[1] = HOLD1;
  endfunction

  function automatic bit model_hit(input int k);
    return (BP_EN === 1'b1) && (PC == BP_ADDR) && m_armed[k];
  endfunction

  function automatic bit model_en(input int k);
    return (m_state[k] == S_RUN && !model_hit(k)) || (m_state[k] == S_STEP);
  endfunction

  function automatic void model_edge();
    bit ep, sp, en, hit, busy;
    ep = 1'b0;
    sp = 1'b0;
    qe.push_back(EXEC);
    qs.push_back(STEP);
    if (settled_other(qe, db_e)) begin db_e = ~db_e; ep = db_e; end
    if (settled_other(qs, db_s)) begin db_s = ~db_s; sp = db_s; end
    while (qe.size() > D + 2) void'(qe.pop_front());
    while (qs.size() > D + 2) void'(qs.pop_front());
    for (int k = 0; k < 2; k++) begin
      en   = model_en(k);
      hit  = model_hit(k);
      busy = (m_hold[k] > 0);
      if (en) m_cnt[k]++;
      case (m_state[k])
        S_STOP: begin
          if (!busy) begin
            if (ep) begin m_state[k] = S_RUN; m_armed[k] = 1'b0; end
            else if (sp) m_state[k] = S_STEP;
          end
        end
        S_RUN: begin
          if (en) m_armed[k] = 1'b1;
          if (HALT_REQ && en) m_state[k] = S_HALT;
          else if (ep)        m_state[k] = S_STOP;
          else if (hit)       m_state[k] = S_STOP;
        end
        S_STEP:  m_state[k] = HALT_REQ ? S_HALT : S_STOP;
        default: ;
      endcase
      if (busy) m_hold[k]--;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("state0",  32'(st0),     32'(m_state[0]));
    chk("cpu_en0", 32'(cpu_en0), 32'(model_en(0)));
    chk("res0",    32'(res0),    32'(m_hold[0] > 0));
    chk("run0",    32'(run0),    32'(m_state[0] == S_RUN));
    chk("cnt0",    32'(cnt0),    m_cnt[0] & 32'hFFFF);
    chk("state1",  32'(st1),     32'(m_state[1]));
    chk("cpu_en1", 32'(cpu_en1), 32'(model_en(1)));
    chk("res1",    32'(res1),    32'(m_hold[1] > 0));
    chk("run1",    32'(run1),    32'(m_state[1] == S_RUN));
    chk("cnt1",    32'(cnt1),    m_cnt[1] & 32'hF);
  endtask

  // Checks sit at the falling edge; inputs change 1 time unit after the rising edge.
  task automatic tick();
    bit en0;
    @(negedge CLOCK);
    check_all();
    en0 = model_en(0);
    if (!RESET) model_edge();
    @(posedge CLOCK);
    #1;
    if (en0 && !RESET) PC = PC + 8'd1;
  endtask

  task automatic do_reset(input int settle);
    RESET = 1'b1;
    PC    = 8'd0;
    model_reset();
    repeat (2) tick();
    RESET = 1'b0;
    repeat (settle) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; EXEC = 1'b0; STEP = 1'b0; HALT_REQ = 1'b0;
    BP_EN = 1'b0; BP_ADDR = 8'd0; PC = 8'd0;
    model_reset();
    repeat (3) tick();
    chk("rst_state", 32'(st0), 0);
    chk("rst_res",   32'(res0), 1);
    chk("rst_cnt",   32'(cnt0), 0);

    // Reset hold; EXEC pressed straight out of reset
    RESET = 1'b0;
    EXEC  = 1'b1;
    repeat (3) tick();
    chk("hold_res_edge3", 32'(res0), 1);
    tick();
    chk("hold_res_edge4", 32'(res0), 0);
    chk("hold1_res_edge4", 32'(res1), 1);
    repeat (3) tick();
    chk("hold_gate_run0",  32'(st0), 1);
    chk("hold_gate_stop1", 32'(st1), 0);
    chk("hold_gate_cnt1",  32'(cnt1), 0);
    EXEC = 1'b0;
    repeat (8) tick();

    // Debounce: 2-cycle glitch, then a clean press held 10 cycles, release, second press
    do_reset(8);
    EXEC = 1'b1; repeat (2) tick(); EXEC = 1'b0; repeat (6) tick();
    chk("glitch_stop", 32'(st0), 0);
    EXEC = 1'b1; repeat (5) tick();
    chk("db_not_yet", 32'(st0), 0);
    tick();
    chk("db_run", 32'(st0), 1);
    chk("db_en",  32'(cpu_en0), 1);
    repeat (4) tick();
    EXEC = 1'b0; repeat (8) tick();
    EXEC = 1'b1; repeat (6) tick();
    chk("db_stop",   32'(st0), 0);
    chk("db_runcnt", 32'(cnt0), 18);
    EXEC = 1'b0; repeat (8) tick();

    // Single step x3
    do_reset(8);
    for (int i = 0; i < 3; i++) begin
      STEP = 1'b1; repeat (6) tick();
      chk("step_state", 32'(st0), 2);
      chk("step_en",    32'(cpu_en0), 1);
      tick();
      chk("step_back",  32'(st0), 0);
      chk("step_en_off", 32'(cpu_en0), 0);
      STEP = 1'b0; repeat (8) tick();
    end
    chk("step_cnt", 32'(cnt0), 3);

    // Breakpoint at 0x05 and resume
    do_reset(8);
    BP_EN = 1'b1; BP_ADDR = 8'h05;
    EXEC = 1'b1; repeat (8) tick(); EXEC = 1'b0; repeat (10) tick();
    chk("bp_state", 32'(st0), 0);
    chk("bp_en",    32'(cpu_en0), 0);
    chk("bp_cnt",   32'(cnt0), 5);
    EXEC = 1'b1; repeat (7) tick();
    chk("bp_resume_state", 32'(st0), 1);
    chk("bp_resume_cnt",   32'(cnt0), 6);
    EXEC = 1'b0; repeat (8) tick();
    BP_EN = 1'b0;

    // Halt is sticky until reset
    do_reset(8);
    EXEC = 1'b1; repeat (8) tick(); EXEC = 1'b0; repeat (2) tick();
    HALT_REQ = 1'b1; tick(); HALT_REQ = 1'b0;
    chk("halt_state", 32'(st0), 3);
    chk("halt_en",    32'(cpu_en0), 0);
    repeat (6) tick();
    EXEC = 1'b1; STEP = 1'b1; repeat (8) tick();
    EXEC = 1'b0; STEP = 1'b0; repeat (8) tick();
    chk("halt_sticky", 32'(st0), 3);
    do_reset(0);
    chk("halt_reset", 32'(st0), 0);

    // Priorities: EXEC over STEP, HALT_REQ over exec_p
    do_reset(8);
    EXEC = 1'b1; STEP = 1'b1; repeat (6) tick();
    chk("prio_exec_step", 32'(st0), 1);
    EXEC = 1'b0; STEP = 1'b0; repeat (8) tick();
    EXEC = 1'b1; repeat (5) tick();
    HALT_REQ = 1'b1; tick(); HALT_REQ = 1'b0;
    chk("prio_halt_exec", 32'(st0), 3);
    EXEC = 1'b0;

    // Asynchronous reset while running
    do_reset(8);
    EXEC = 1'b1; repeat (8) tick();
    RESET = 1'b1; PC = 8'd0; model_reset();
    #1;
    chk("async_rst_state", 32'(st0), 0);
    chk("async_rst_en",    32'(cpu_en0), 0);
    chk("async_rst_cnt",   32'(cnt0), 0);
    EXEC = 1'b0;
    tick();
    RESET = 1'b0;
    repeat (8) tick();

    // Counter wrap on the 4-bit instance: 17 steps
    do_reset(8);
    for (int i = 0; i < 17; i++) begin
      STEP = 1'b1; repeat (7) tick();
      STEP = 1'b0; repeat (7) tick();
    end
    chk("wrap_cnt4",  32'(cnt1), 1);
    chk("wrap_cnt16", 32'(cnt0), 17);

    // Random buttons, halts, breakpoints and resets
    do_reset(8);
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 11) == 0) EXEC = ~EXEC;
      if ($urandom_range(0, 11) == 0) STEP = ~STEP;
      HALT_REQ = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 99) == 0) BP_EN = ~BP_EN;
      if ($urandom_range(0, 49) == 0) BP_ADDR = PC + 8'($urandom_range(0, 12));
      if ($urandom_range(0, 249) == 0) begin
        RESET = 1'b1; PC = 8'd0; model_reset();
      end else begin
        RESET = 1'b0;
      end
      tick();
    end
    RESET = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exec_step_controller.md
Name: exec_step_controller

Overview:
- Sequences the processor core's execution from the board's EXEC (run/stop) and STEP push-buttons.
- Produces a single clock-enable for the datapath instead of a gated clock.
- Debounces both buttons, supports single-step, a PC breakpoint and a core-requested halt, and stretches reset into a clean reset hold for the core.
- Sits between the board I/O and the core, replacing any clock-gating logic on CLOCK.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable samples required before a button level is accepted (must be ≥1)
DB_W, 16, width of the debounce counters (must hold DEBOUNCE_CYCLES)
PC_W, 8, width of the program counter and breakpoint address
RST_HOLD, 4, CLOCK cycles RES_SIG stays high after RESET deasserts (must be ≥1)
CNT_W, 16, width of the executed-instruction counter

Ports:
CLOCK  input  1  single system clock; all state on its rising edge
RESET  input  1  asynchronous, active-high reset
EXEC  input  1  raw run/stop button, asynchronous and bouncy
STEP  input  1  raw single-step button, asynchronous and bouncy
HALT_REQ  input  1  core has decoded a halt instruction; meaningful only while CPU_EN=1
BP_EN  input  1  breakpoint enable
BP_ADDR  input  PC_W  breakpoint address
PC  input  PC_W  current core program counter
CPU_EN  output  1  datapath clock enable; core advances one instruction per cycle with CPU_EN=1
RES_SIG  output  1  reset to the core
RUNNING  output  1  high in RUN state
STATE  output  2  0=STOP, 1=RUN, 2=STEP, 3=HALTED
INSTR_CNT  output  CNT_W  number of cycles with CPU_EN=1; wraps modulo 2^CNT_W

Behaviour:
- Reset: RESET high asynchronously sets the following.
  - STATE=STOP, CPU_EN=0, RUNNING=0, INSTR_CNT=0, RES_SIG=1.
  - Debounce counters cleared; debounced levels=0; bp_armed=0.
- Reset release: after RESET falls, RES_SIG stays 1 for exactly RST_HOLD rising edges, then 0. While RES_SIG=1, button presses are ignored and STATE stays STOP.
- Synchroniser: each button passes through a 2-flop synchroniser.
- Debounce:
  - A counter increments while the synchronised level differs from the debounced level and resets to 0 on agreement.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A 0→1 flip of the debounced level produces a one-cycle press pulse (exec_p / step_p).
  - Latency from a clean raw edge to the press pulse is 2 + DEBOUNCE_CYCLES cycles. Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- bp_hit = BP_EN & (PC == BP_ADDR) & bp_armed.
- CPU_EN (combinational from state, not from raw inputs) = (STATE==RUN & ~bp_hit) | (STATE==STEP).
- Breakpoint semantics: on a hit, the instruction at BP_ADDR is not executed.
- State transitions (evaluated each edge, in priority order):
  - STOP:
    - exec_p → RUN, bp_armed=0.
    - else step_p → STEP.
    - exec_p and step_p in the same cycle: EXEC wins.
    - HALT_REQ is ignored.
  - RUN:
    - HALT_REQ & CPU_EN → HALTED.
    - else exec_p → STOP.
    - else bp_hit → STOP.
    - else stay in RUN.
    - bp_armed is set to 1 on the first cycle with CPU_EN=1. Resuming at PC==BP_ADDR therefore executes that instruction and does not re-trigger immediately.
  - STEP:
    - Lasts exactly one cycle with CPU_EN=1.
    - Next state is HALTED if HALT_REQ, else STOP.
    - Button presses in this cycle are discarded.
    - Breakpoints are ignored in STEP.
  - HALTED:
    - CPU_EN=0.
    - All presses and HALT_REQ are ignored.
    - Exited only by RESET.
- INSTR_CNT increments by 1 on every edge where CPU_EN=1, and wraps from all-ones to 0.
- RUNNING = (STATE==RUN).
- STATE is a registered output.
- Reset mid-operation: RESET asserted in any state immediately forces the reset values, including during RUN with CPU_EN=1. The in-flight cycle is not counted.
- Holding a button: a held button yields exactly one press pulse. Re-triggering requires release to be debounced first.

Test Plan:
- Reset/hold: RESET high 3 cycles then low, RST_HOLD=4 → RES_SIG falls on the 4th edge after release. Presses during the hold produce STATE=STOP and INSTR_CNT=0.
- Debounce: EXEC toggled with a 2-cycle glitch, then held high 10 cycles, DEBOUNCE_CYCLES=4 → no transition on the glitch; STATE=RUN 6 cycles after the stable rise; CPU_EN=1 continuously. A second clean press → STOP; INSTR_CNT equals the number of RUN cycles.
- Single step: three STEP presses from STOP → three isolated 1-cycle CPU_EN pulses; INSTR_CNT=3; STATE returns to 0 after each.
- Breakpoint: BP_EN=1, BP_ADDR=0x05, PC increments per CPU_EN from 0.
  - EXEC press → CPU_EN for PC 0..4 only; STATE=STOP with PC=5; INSTR_CNT=5.
  - A second EXEC press executes PC=5 and continues running.
- Halt: HALT_REQ=1 in a RUN cycle → STATE=3 next edge; CPU_EN=0; subsequent EXEC/STEP presses are ignored; RESET → STOP.
- Priority and counter wrap:
  - EXEC and STEP pressed in the same cycle in STOP → RUN.
  - HALT_REQ and exec_p in the same RUN cycle → HALTED.
  - With CNT_W=4, 17 steps → INSTR_CNT=1.
